// File: rtl/act_cmd_sequencer.sv
// act_cmd_sequencer: walks N elements through read -> activation unit -> write.
// Optional build macro: ACT_SEQ_TIMEOUT_EN adds a 5-bit WAIT-state watchdog
// that abandons the command with an err pulse after 16 silent WAIT cycles.
module act_cmd_sequencer #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DIM_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [6:0]            cmd_opcode,
  input  logic [ADDR_WIDTH-1:0] cmd_in_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_out_addr,
  input  logic [DIM_WIDTH-1:0]  cmd_dim,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  af_valid_in,
  output logic [6:0]            af_opcode,
  output logic [DATA_WIDTH-1:0] af_data,
  input  logic [DATA_WIDTH-1:0] af_result,
  input  logic                  af_valid_out,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned OP_WIDTH = 7;
  localparam logic [OP_WIDTH-1:0] OP_SIGMOID = 7'h4A;
  localparam logic [OP_WIDTH-1:0] OP_TANH    = 7'h4B;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_FEED  = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // FSM state and latched command fields
  state_t                r_state;
  state_t                w_state_nxt;
  logic [OP_WIDTH-1:0]   r_opcode;
  logic [OP_WIDTH-1:0]   w_opcode_nxt;
  logic [ADDR_WIDTH-1:0] r_in_addr;
  logic [ADDR_WIDTH-1:0] w_in_addr_nxt;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [ADDR_WIDTH-1:0] w_out_addr_nxt;
  logic [DIM_WIDTH-1:0]  r_dim;
  logic [DIM_WIDTH-1:0]  w_dim_nxt;
  logic [DIM_WIDTH-1:0]  r_idx;
  logic [DIM_WIDTH-1:0]  w_idx_nxt;

  // Registered output copies
  logic                  r_cmd_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_mem_rd_en;
  logic [ADDR_WIDTH-1:0] r_mem_rd_addr;
  logic                  r_af_valid_in;
  logic                  r_mem_wr_en;
  logic [ADDR_WIDTH-1:0] r_mem_wr_addr;
  logic [DATA_WIDTH-1:0] r_mem_wr_data;

  // Decode helpers
  logic                  w_accept;
  logic                  w_legal;
  logic                  w_last;
  logic                  w_capture;
  logic                  w_err_nxt;

  assign w_accept = cmd_valid && (r_state == S_IDLE);
  assign w_legal  = (cmd_opcode == OP_SIGMOID) || (cmd_opcode == OP_TANH);
  assign w_last   = (r_idx == (r_dim - DIM_WIDTH'(1)));

`ifdef ACT_SEQ_TIMEOUT_EN
  localparam int unsigned WD_WIDTH = 5;
  localparam logic [WD_WIDTH-1:0] WD_LIMIT = 5'd15;

  logic [WD_WIDTH-1:0]   r_wd;

  // Watchdog: zero outside WAIT so it restarts on every WAIT entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd <= '0;
    end else if (r_state != S_WAIT) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + WD_WIDTH'(1);
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, command-field and event decode
  always_comb begin
    w_state_nxt    = r_state;
    w_opcode_nxt   = r_opcode;
    w_in_addr_nxt  = r_in_addr;
    w_out_addr_nxt = r_out_addr;
    w_dim_nxt      = r_dim;
    w_idx_nxt      = r_idx;
    w_capture      = 1'b0;
    w_err_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_opcode_nxt   = cmd_opcode;
          w_in_addr_nxt  = cmd_in_addr;
          w_out_addr_nxt = cmd_out_addr;
          w_dim_nxt      = cmd_dim;
          w_idx_nxt      = '0;
          // Illegal opcodes are rejected before the length is considered
          if (!w_legal) begin
            w_err_nxt = 1'b1;
          end else if (cmd_dim == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_READ;
          end
        end
      end
      S_READ: begin
        w_state_nxt = S_FEED;
      end
      S_FEED: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (af_valid_out) begin
          w_capture   = 1'b1;
          w_state_nxt = S_WRITE;
        end
`ifdef ACT_SEQ_TIMEOUT_EN
        else if (r_wd == WD_LIMIT) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      S_WRITE: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_idx + DIM_WIDTH'(1);
          w_state_nxt = S_READ;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Latched command fields and element index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opcode   <= '0;
      r_in_addr  <= '0;
      r_out_addr <= '0;
      r_dim      <= '0;
      r_idx      <= '0;
    end else begin
      r_opcode   <= w_opcode_nxt;
      r_in_addr  <= w_in_addr_nxt;
      r_out_addr <= w_out_addr_nxt;
      r_dim      <= w_dim_nxt;
      r_idx      <= w_idx_nxt;
    end
  end

  // Outputs registered from the next state so each strobe lines up with its state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_mem_rd_en   <= 1'b0;
      r_mem_rd_addr <= '0;
      r_af_valid_in <= 1'b0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_addr <= '0;
      r_mem_wr_data <= '0;
    end else begin
      r_cmd_ready   <= (w_state_nxt == S_IDLE);
      r_busy        <= (w_state_nxt != S_IDLE);
      r_done        <= (w_state_nxt == S_DONE);
      r_err         <= w_err_nxt;
      r_mem_rd_en   <= (w_state_nxt == S_READ);
      r_mem_rd_addr <= (w_state_nxt == S_READ) ?
                       (w_in_addr_nxt + ADDR_WIDTH'(w_idx_nxt)) : '0;
      r_af_valid_in <= (w_state_nxt == S_FEED);
      r_mem_wr_en   <= (w_state_nxt == S_WRITE);
      r_mem_wr_addr <= (w_state_nxt == S_WRITE) ?
                       (w_out_addr_nxt + ADDR_WIDTH'(w_idx_nxt)) : '0;
      r_mem_wr_data <= w_capture ? af_result : '0;
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign mem_rd_en   = r_mem_rd_en;
  assign mem_rd_addr = r_mem_rd_addr;
  assign af_valid_in = r_af_valid_in;
  assign af_opcode   = r_opcode;
  assign mem_wr_en   = r_mem_wr_en;
  assign mem_wr_addr = r_mem_wr_addr;
  assign mem_wr_data = r_mem_wr_data;

  // Read data arrives in FEED, so the operand is passed straight through then
  assign af_data = r_af_valid_in ? mem_rd_data : '0;

endmodule

// File: tb/tb_act_cmd_sequencer.sv
// Testbench for act_cmd_sequencer: memory + latency-2 activation unit models,
// and a sequential reference model of each command.
module tb_act_cmd_sequencer;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 4;
  localparam int L = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [6:0]    cmd_opcode;
  logic [AW-1:0] cmd_in_addr;
  logic [AW-1:0] cmd_out_addr;
  logic [NW-1:0] cmd_dim;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          af_valid_in;
  logic [6:0]    af_opcode;
  logic [DW-1:0] af_data;
  logic [DW-1:0] af_result = '0;
  logic          af_valid_out = 1'b0;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  act_cmd_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DIM_WIDTH(NW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_in_addr(cmd_in_addr), .cmd_out_addr(cmd_out_addr), .cmd_dim(cmd_dim),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .af_valid_in(af_valid_in), .af_opcode(af_opcode), .af_data(af_data),
    .af_result(af_result), .af_valid_out(af_valid_out),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0] mem     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];

  // Logs filled by the monitor (stamp = edge count at which the value was seen)
  int            rd_cyc[$];
  logic [AW-1:0] rd_addr[$];
  int            wr_cyc[$];
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  int            done_cyc[$];
  int            err_cyc[$];
  int            afv_n = 0;
  int            opc_bad = 0;
  int            both_bad = 0;
  logic [6:0]    exp_op = 7'h00;
  bit            af_stall = 1'b0;

  // Expected traffic of the most recent modelled command
  logic [AW-1:0] exp_rd[$];
  logic [AW-1:0] exp_wa[$];
  logic [DW-1:0] exp_wd[$];

  logic [DW-1:0] af_q[$];
  int            af_due[$];

  function automatic logic [DW-1:0] af_fn(input logic [6:0] op, input logic [DW-1:0] x);
    if (op == 7'h4A) return x * DW'(3) + DW'(1);
    return {x[15:0], x[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  // Memory with one-cycle read latency, and an activation unit of latency L
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    else           mem_rd_data <= $urandom;
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (af_valid_in) begin
      af_q.push_back(af_fn(af_opcode, af_data));
      af_due.push_back(cyc + L - 1);
    end
    af_valid_out <= 1'b0;
    if (af_due.size() > 0 && cyc >= af_due[0] && !af_stall) begin
      af_valid_out <= 1'b1;
      af_result    <= af_q.pop_front();
      void'(af_due.pop_front());
    end
  end

  // Bus monitor
  always @(posedge clk) begin
    if (mem_rd_en) begin rd_cyc.push_back(cyc); rd_addr.push_back(mem_rd_addr); end
    if (mem_wr_en) begin
      wr_cyc.push_back(cyc); wr_addr.push_back(mem_wr_addr); wr_data.push_back(mem_wr_data);
    end
    if (done) done_cyc.push_back(cyc);
    if (err)  err_cyc.push_back(cyc);
    if (af_valid_in) afv_n++;
    if (mem_rd_en && mem_wr_en) both_bad++;
    if (busy && af_opcode !== exp_op) opc_bad++;
    cyc <= cyc + 1;
  end

  // Sequential reference: element j reads in+j, writes out+j, in order
  task automatic model_cmd(input logic [6:0] op, input logic [AW-1:0] ia,
                           input logic [AW-1:0] oa, input int n);
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    for (int j = 0; j < n; j++) begin
      logic [AW-1:0] ra, wa;
      logic [DW-1:0] r;
      ra = ia + AW'(j);
      wa = oa + AW'(j);
      r  = af_fn(op, ref_mem[ra]);
      ref_mem[wa] = r;
      exp_rd.push_back(ra); exp_wa.push_back(wa); exp_wd.push_back(r);
    end
  endtask

  // Offer a command and wait (bounded) for the accepting edge
  task automatic issue(input logic [6:0] op, input logic [AW-1:0] ia, input logic [AW-1:0] oa,
                       input logic [NW-1:0] n, output int acc, output bit ok);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_in_addr = ia; cmd_out_addr = oa; cmd_dim = n;
    ok = 1'b0; acc = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (cmd_ready) begin
        @(posedge clk);
        acc = cyc;
        ok  = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    checks++;
    if ({busy, done, err, mem_rd_en, mem_wr_en, af_valid_in} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 000000", {busy, done, err, mem_rd_en, mem_wr_en, af_valid_in});
    end
    checks++;
    if (af_opcode !== 7'h00) begin errors++; $display("FAIL reset_opcode: got %h want 00", af_opcode); end
    rst = 1'b0;
  endtask

  task automatic test_sigmoid();
    int acc, rb, wb, db, eb, ab, ob; bit ok;
    rb = rd_addr.size(); wb = wr_addr.size(); db = done_cyc.size(); eb = err_cyc.size();
    ab = afv_n; ob = opc_bad;
    model_cmd(7'h4A, 12'h001, 12'h010, 4);
    exp_op = 7'h4A;
    issue(7'h4A, 12'h001, 12'h010, 4'd4, acc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sig_accept: got no accept want accept"); end
    repeat (24) @(posedge clk); @(negedge clk);
    checks++;
    if (rd_addr.size() - rb !== 4 || wr_addr.size() - wb !== 4) begin
      errors++; $display("FAIL sig_counts: got rd %0d wr %0d want 4 4", rd_addr.size() - rb, wr_addr.size() - wb);
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (rd_addr[rb+j] !== AW'(12'h001 + j) || rd_cyc[rb+j] - acc !== j * (L + 3) + 1) begin
        errors++; $display("FAIL sig_read%0d: got %h@+%0d want %h@+%0d", j, rd_addr[rb+j],
                           rd_cyc[rb+j] - acc, exp_rd[j], j * (L + 3) + 1);
      end
      checks++;
      if (wr_addr[wb+j] !== exp_wa[j] || wr_data[wb+j] !== exp_wd[j] || wr_cyc[wb+j] - acc !== (j + 1) * (L + 3)) begin
        errors++; $display("FAIL sig_write%0d: got %h=%h@+%0d want %h=%h@+%0d", j, wr_addr[wb+j], wr_data[wb+j],
                           wr_cyc[wb+j] - acc, exp_wa[j], exp_wd[j], (j + 1) * (L + 3));
      end
    end
    checks++;
    if (done_cyc.size() - db !== 1 || done_cyc[db] - acc !== 21) begin
      errors++; $display("FAIL sig_done: got %0d pulses first@+%0d want 1@+21", done_cyc.size() - db, done_cyc[db] - acc);
    end
    checks++;
    if (opc_bad - ob !== 0 || err_cyc.size() - eb !== 0 || afv_n - ab !== 4) begin
      errors++; $display("FAIL sig_misc: got opbad %0d err %0d afv %0d want 0 0 4", opc_bad - ob, err_cyc.size() - eb, afv_n - ab);
    end
  endtask

  task automatic test_tanh_wrap();
    int acc, rb, wb, db; bit ok;
    logic [AW-1:0] want_rd [3];
    want_rd[0] = 12'hFFE; want_rd[1] = 12'hFFF; want_rd[2] = 12'h000;
    rb = rd_addr.size(); wb = wr_addr.size(); db = done_cyc.size();
    model_cmd(7'h4B, 12'hFFE, 12'hFFF, 3);
    exp_op = 7'h4B;
    issue(7'h4B, 12'hFFE, 12'hFFF, 4'd3, acc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tanh_accept: got no accept want accept"); end
    repeat (20) @(posedge clk); @(negedge clk);
    checks++;
    if (rd_addr.size() - rb !== 3 || wr_addr.size() - wb !== 3) begin
      errors++; $display("FAIL tanh_counts: got rd %0d wr %0d want 3 3", rd_addr.size() - rb, wr_addr.size() - wb);
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (rd_addr[rb+j] !== want_rd[j] || wr_addr[wb+j] !== exp_wa[j] || wr_data[wb+j] !== exp_wd[j]) begin
        errors++; $display("FAIL tanh_elem%0d: got rd %h wr %h=%h want rd %h wr %h=%h", j, rd_addr[rb+j],
                           wr_addr[wb+j], wr_data[wb+j], want_rd[j], exp_wa[j], exp_wd[j]);
      end
    end
    checks++;
    if (done_cyc.size() - db !== 1) begin errors++; $display("FAIL tanh_done: got %0d pulses want 1", done_cyc.size() - db); end
  endtask

  task automatic test_illegal();
    logic [6:0] ops [4];
    ops[0] = 7'h00; ops[1] = 7'h4C; ops[2] = 7'h49; ops[3] = 7'h7F;
    for (int t = 0; t < 4; t++) begin
      int acc, rb, wb, db, eb, ab; bit ok;
      rb = rd_addr.size(); wb = wr_addr.size(); db = done_cyc.size(); eb = err_cyc.size(); ab = afv_n;
      issue(ops[t], AW'($urandom), AW'($urandom), 4'd4, acc, ok);
      @(negedge clk);
      checks++;
      if (!ok || cmd_ready !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL illegal_ready_%h: got ok %b ready %b busy %b want 1 1 0", ops[t], ok, cmd_ready, busy);
      end
      repeat (8) @(posedge clk); @(negedge clk);
      checks++;
      if (err_cyc.size() - eb !== 1 || err_cyc[eb] - acc !== 1) begin
        errors++; $display("FAIL illegal_err_%h: got %0d pulses first@+%0d want 1@+1", ops[t], err_cyc.size() - eb, err_cyc[eb] - acc);
      end
      checks++;
      if (rd_addr.size() - rb + wr_addr.size() - wb + afv_n - ab + done_cyc.size() - db !== 0) begin
        errors++; $display("FAIL illegal_traffic_%h: got %0d events want 0", ops[t],
                           rd_addr.size() - rb + wr_addr.size() - wb + afv_n - ab + done_cyc.size() - db);
      end
    end
  endtask

  task automatic test_zero_len();
    int acc, rb, wb, db, ab; bit ok;
    rb = rd_addr.size(); wb = wr_addr.size(); db = done_cyc.size(); ab = afv_n;
    exp_op = 7'h4A;
    issue(7'h4A, 12'h123, 12'h456, 4'd0, acc, ok);
    repeat (6) @(posedge clk); @(negedge clk);
    checks++;
    if (!ok || done_cyc.size() - db !== 1 || done_cyc[db] - acc !== 1) begin
      errors++; $display("FAIL zero_done: got %0d pulses first@+%0d want 1@+1", done_cyc.size() - db, done_cyc[db] - acc);
    end
    checks++;
    if (rd_addr.size() - rb + wr_addr.size() - wb + afv_n - ab !== 0) begin
      errors++; $display("FAIL zero_traffic: got %0d events want 0", rd_addr.size() - rb + wr_addr.size() - wb + afv_n - ab);
    end
  endtask

  task automatic test_reset_in_wait();
    int acc, wb, db, eb; bit ok;
    logic [AW-1:0] ia, oa;
    ia = AW'($urandom); oa = AW'($urandom);
    wb = wr_addr.size(); db = done_cyc.size(); eb = err_cyc.size();
    model_cmd(7'h4A, ia, oa, 2);
    exp_op = 7'h4A;
    issue(7'h4A, ia, oa, 4'd4, acc, ok);
    // Element 2 is in WAIT during the cycles stamped +13 and +14
    repeat (12) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || {busy, done, err, mem_rd_en, mem_wr_en, af_valid_in} !== 6'b0 || af_opcode !== 7'h00) begin
      errors++; $display("FAIL rstwait_idle: got ready %b strobes %b op %h want 1 000000 00", cmd_ready,
                         {busy, done, err, mem_rd_en, mem_wr_en, af_valid_in}, af_opcode);
    end
    rst = 1'b0;
    repeat (20) @(posedge clk); @(negedge clk);
    checks++;
    if (!ok || wr_addr.size() - wb !== 2) begin
      errors++; $display("FAIL rstwait_writes: got %0d want 2", wr_addr.size() - wb);
    end
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (wr_addr[wb+j] !== exp_wa[j] || wr_data[wb+j] !== exp_wd[j]) begin
        errors++; $display("FAIL rstwait_w%0d: got %h=%h want %h=%h", j, wr_addr[wb+j], wr_data[wb+j], exp_wa[j], exp_wd[j]);
      end
    end
    checks++;
    if (done_cyc.size() - db + err_cyc.size() - eb !== 0) begin
      errors++; $display("FAIL rstwait_events: got %0d done/err want 0", done_cyc.size() - db + err_cyc.size() - eb);
    end
  endtask

`ifdef ACT_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int acc, wb, db, eb; bit ok;
    wb = wr_addr.size(); db = done_cyc.size(); eb = err_cyc.size();
    af_stall = 1'b1;
    exp_op = 7'h4B;
    issue(7'h4B, 12'h200, 12'h300, 4'd2, acc, ok);
    repeat (30) @(posedge clk); @(negedge clk);
    checks++;
    if (!ok || err_cyc.size() - eb !== 1 || err_cyc[eb] - acc !== 19) begin
      errors++; $display("FAIL timeout_err: got %0d pulses first@+%0d want 1@+19", err_cyc.size() - eb, err_cyc[eb] - acc);
    end
    checks++;
    if (wr_addr.size() - wb + done_cyc.size() - db !== 0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_idle: got wr+done %0d busy %b ready %b want 0 0 1",
                         wr_addr.size() - wb + done_cyc.size() - db, busy, cmd_ready);
    end
    // The source element was read but never written back
    void'(ref_mem[12'h200]);
    af_stall = 1'b0;
    repeat (4) @(posedge clk);
  endtask
`else
  task automatic test_wait_hold();
    int acc, wb, db, eb; bit ok;
    logic [AW-1:0] ia, oa;
    ia = AW'($urandom); oa = AW'($urandom);
    wb = wr_addr.size(); db = done_cyc.size(); eb = err_cyc.size();
    model_cmd(7'h4A, ia, oa, 1);
    af_stall = 1'b1;
    exp_op = 7'h4A;
    issue(7'h4A, ia, oa, 4'd1, acc, ok);
    repeat (40) @(posedge clk); @(negedge clk);
    checks++;
    if (!ok || busy !== 1'b1 || err_cyc.size() - eb !== 0 || wr_addr.size() - wb !== 0) begin
      errors++; $display("FAIL hold_waiting: got busy %b err %0d wr %0d want 1 0 0", busy, err_cyc.size() - eb, wr_addr.size() - wb);
    end
    af_stall = 1'b0;
    repeat (8) @(posedge clk); @(negedge clk);
    checks++;
    if (wr_addr.size() - wb !== 1 || wr_addr[wb] !== exp_wa[0] || wr_data[wb] !== exp_wd[0] || done_cyc.size() - db !== 1) begin
      errors++; $display("FAIL hold_release: got %0d wr %h=%h done %0d want 1 %h=%h 1", wr_addr.size() - wb,
                         wr_addr[wb], wr_data[wb], done_cyc.size() - db, exp_wa[0], exp_wd[0]);
    end
  endtask
`endif

  task automatic test_back_to_back();
    int acc_a, acc_b, wb, db; bit ok_a, ok_b;
    logic [AW-1:0] wa[$];
    logic [DW-1:0] wd[$];
    logic [AW-1:0] ia_a, oa_a, ia_b, oa_b;
    ia_a = AW'($urandom); oa_a = AW'($urandom); ia_b = AW'($urandom); oa_b = AW'($urandom);
    wb = wr_addr.size(); db = done_cyc.size();
    model_cmd(7'h4B, ia_a, oa_a, 3);
    wa = exp_wa; wd = exp_wd;
    model_cmd(7'h4A, ia_b, oa_b, 2);
    for (int j = 0; j < 2; j++) begin wa.push_back(exp_wa[j]); wd.push_back(exp_wd[j]); end
    exp_op = 7'h4B;
    issue(7'h4B, ia_a, oa_a, 4'd3, acc_a, ok_a);
    issue(7'h4A, ia_b, oa_b, 4'd2, acc_b, ok_b);
    exp_op = 7'h4A;
    checks++;
    if (!ok_a || !ok_b || acc_b - acc_a !== 3 * (L + 3) + 2) begin
      errors++; $display("FAIL b2b_gap: got %0d want %0d", acc_b - acc_a, 3 * (L + 3) + 2);
    end
    repeat (16) @(posedge clk); @(negedge clk);
    checks++;
    if (wr_addr.size() - wb !== 5 || done_cyc.size() - db !== 2) begin
      errors++; $display("FAIL b2b_counts: got wr %0d done %0d want 5 2", wr_addr.size() - wb, done_cyc.size() - db);
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (wr_addr[wb+j] !== wa[j] || wr_data[wb+j] !== wd[j]) begin
        errors++; $display("FAIL b2b_w%0d: got %h=%h want %h=%h", j, wr_addr[wb+j], wr_data[wb+j], wa[j], wd[j]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int acc, rb, wb, db, ab, ob, bb, n; bit ok;
      logic [6:0] op;
      logic [AW-1:0] ia, oa;
      op = ($urandom_range(0, 1) == 0) ? 7'h4A : 7'h4B;
      n  = $urandom_range(1, 15);
      ia = AW'($urandom); oa = AW'($urandom);
      rb = rd_addr.size(); wb = wr_addr.size(); db = done_cyc.size(); ab = afv_n; ob = opc_bad; bb = both_bad;
      model_cmd(op, ia, oa, n);
      exp_op = op;
      issue(op, ia, oa, NW'(n), acc, ok);
      repeat (n * (L + 3) + 4) @(posedge clk); @(negedge clk);
      checks++;
      if (!ok || rd_addr.size() - rb !== n || wr_addr.size() - wb !== n || afv_n - ab !== n) begin
        errors++; $display("FAIL rand%0d_counts: got rd %0d wr %0d af %0d want %0d", t,
                           rd_addr.size() - rb, wr_addr.size() - wb, afv_n - ab, n);
      end
      for (int j = 0; j < n; j++) begin
        checks++;
        if (rd_addr[rb+j] !== exp_rd[j] || wr_addr[wb+j] !== exp_wa[j] || wr_data[wb+j] !== exp_wd[j]) begin
          errors++; $display("FAIL rand%0d_e%0d: got rd %h wr %h=%h want rd %h wr %h=%h", t, j, rd_addr[rb+j],
                             wr_addr[wb+j], wr_data[wb+j], exp_rd[j], exp_wa[j], exp_wd[j]);
        end
      end
      checks++;
      if (done_cyc.size() - db !== 1 || done_cyc[db] - acc !== n * (L + 3) + 1 || opc_bad - ob !== 0 || both_bad - bb !== 0) begin
        errors++; $display("FAIL rand%0d_done: got %0d pulses @+%0d opbad %0d both %0d want 1 @+%0d 0 0", t,
                           done_cyc.size() - db, done_cyc[db] - acc, opc_bad - ob, both_bad - bb, n * (L + 3) + 1);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) begin
      logic [DW-1:0] v;
      v = $urandom;
      mem[a] = v;
      ref_mem[a] = v;
    end
    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_in_addr = '0; cmd_out_addr = '0; cmd_dim = '0;
    test_reset();
    test_sigmoid();
    test_tanh_wrap();
    test_illegal();
    test_zero_len();
    test_reset_in_wait();
`ifdef ACT_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_wait_hold();
`endif
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/act_cmd_sequencer.md
ACT_CMD_SEQUENCER -- requirements
Module: act_cmd_sequencer

Interface
REQ-001 Parameters: ADDR_WIDTH, default 12, address width; DATA_WIDTH, default 32, data width; DIM_WIDTH, default 4, element-count width.
REQ-002 Ports, one per line:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_opcode  in  7  0x4A sigmoid, 0x4B tanh; all other values illegal.
- cmd_in_addr  in  ADDR_WIDTH  first source element address.
- cmd_out_addr  in  ADDR_WIDTH  first destination element address.
- cmd_dim  in  DIM_WIDTH  element count N.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_WIDTH  read address.
- mem_rd_data  in  DATA_WIDTH  read data, valid exactly one cycle after mem_rd_en.
- af_valid_in  out  1  element issued to the activation unit.
- af_opcode  out  7  latched command opcode.
- af_data  out  DATA_WIDTH  element operand.
- af_result  in  DATA_WIDTH  activation result.
- af_valid_out  in  1  af_result valid.
- mem_wr_en  out  1  memory write strobe.
- mem_wr_addr  out  ADDR_WIDTH  write address.
- mem_wr_data  out  DATA_WIDTH  write data.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  one-cycle pulse on illegal opcode or timeout.

Function
REQ-003 The FSM SHALL have the states IDLE, READ, FEED, WAIT, WRITE and DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-004 Accept (cmd_valid and cmd_ready at a clock edge) SHALL latch opcode, both addresses and N, and clear the element index i.
- Legal opcode, N>0: go to READ.
- N=0: go to DONE with no memory or activation-unit traffic.
- Illegal opcode: pulse err next cycle, stay in IDLE, no traffic, no done.
REQ-005 READ: mem_rd_en=1, mem_rd_addr=in_addr+i; next state FEED.
REQ-006 FEED: af_valid_in=1, af_data=mem_rd_data; next state WAIT.
REQ-007 WAIT: stay until af_valid_out=1; on that cycle capture af_result and go to WRITE. af_valid_out SHALL be ignored in every other state.
REQ-008 WRITE: mem_wr_en=1, mem_wr_addr=out_addr+i, mem_wr_data=captured result.
- If i==N-1: go to DONE.
- Otherwise: i increments and go to READ.
REQ-009 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-010 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH (for example, 0xFFF+1 = 0x000).
REQ-011 Cycle count: with activation-unit latency L≥1 (af_valid_out L cycles after af_valid_in), each element SHALL take L+3 cycles, and done SHALL fall at accept+N(L+3)+1.
REQ-012 af_opcode SHALL hold the latched opcode for the entire command.
REQ-013 All strobes SHALL be 0 outside their own state, and at most one of mem_rd_en and mem_wr_en SHALL be high in any cycle.

Reset
REQ-014 With rst=1 at an edge, the block SHALL enter IDLE regardless of state, clear i and the latched fields, and drive all strobes, busy, done and err to 0 with cmd_ready=1 on the following cycle. Any in-flight command SHALL be discarded with no further writes.

Configuration
REQ-015 With ACT_SEQ_TIMEOUT_EN defined, a 5-bit watchdog SHALL count cycles spent in WAIT.
- It SHALL reset on entry to WAIT.
- If 16 consecutive WAIT cycles pass without af_valid_out, the block SHALL pulse err, perform no write, skip DONE (no done) and return to IDLE.
REQ-016 Without ACT_SEQ_TIMEOUT_EN, WAIT SHALL last indefinitely and the watchdog logic SHALL be absent.

Verification
REQ-017 The bench SHALL model the activation unit with L=2 and cover these scenarios:
- Sigmoid: opcode 0x4A, in 0x001, out 0x010, N=4 -> reads 0x001..0x004; writes 0x010..0x013 at accept+5/10/15/20; done at accept+21; af_opcode=0x4A throughout.
- Tanh, wrapping: opcode 0x4B, in 0xFFE, out 0xFFF, N=3 -> reads 0xFFE, 0xFFF, 0x000; writes 0xFFF, 0x000, 0x001; one done pulse.
- Opcode 0x00, N=4 -> err one cycle after accept; no rd/wr/af strobes; cmd_ready back at 1 the next cycle; no done.
- N=0 with opcode 0x4A -> done at accept+1; zero memory traffic.
- rst asserted in WAIT of element 2 of an N=4 command -> no further mem_wr_en; idle outputs and cmd_ready=1 one cycle later; a new command then completes normally.
- With ACT_SEQ_TIMEOUT_EN and af_valid_out held 0 -> err after 16 WAIT cycles; no write; no done; IDLE.
